// File: rtl/vga_grid_decoder_if.sv
// VGA pixel stream into the grid decoder and the recovered grid/status back out.
interface vga_grid_decoder_if;
  logic        display_clk;
  logic        Hsync;
  logic        Vsync;
  logic [2:0]  vgaRed;
  logic [2:0]  vgaGreen;
  logic [1:0]  vgaBlue;
  logic [97:0] grid;
  logic        grid_valid;
  logic        locked;
  logic        sync_err;
  logic        cell_err;

  modport master (
    output display_clk, Hsync, Vsync, vgaRed, vgaGreen, vgaBlue,
    input  grid, grid_valid, locked, sync_err, cell_err
  );

  modport slave (
    input  display_clk, Hsync, Vsync, vgaRed, vgaGreen, vgaBlue,
    output grid, grid_valid, locked, sync_err, cell_err
  );
endinterface

// File: rtl/vga_grid_decoder.sv
// Loopback monitor for the VGA stream: recovers pixel position from sync edges, samples every
// board cell centre and republishes the 98-bit grid once per frame with clean timing.
module vga_grid_decoder #(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 521,
  parameter int unsigned X0      = 266,
  parameter int unsigned PITCH   = 66,
  parameter int unsigned Y_SEL   = 66,
  parameter int unsigned Y0      = 141
) (
  input logic               clk,
  input logic               rst_n,
  vga_grid_decoder_if.slave vga
);
  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] XStart  = 10'(X0);
  localparam logic [9:0] PitchM1 = 10'(PITCH - 1);
  localparam logic [9:0] YStart  = 10'(Y_SEL);
  localparam logic [9:0] YGapM1  = 10'(Y0 - Y_SEL - 1);
  localparam logic [2:0] IdxDone = 3'd7;
  localparam logic [6:0] TopBit  = 7'd97;

  logic        hs_d, vs_d;
  logic [9:0]  col_q, row_q;
  logic [9:0]  col_wait_q, row_wait_q;
  logic [2:0]  col_idx_q, row_idx_q;
  logic [6:0]  row_base_q;
  logic        seen_hs_q, seen_vs_q, frame_bad_q, cell_bad_q;
  logic [97:0] shadow_q;
  logic [97:0] grid_q;
  logic        grid_valid_q, locked_q, sync_err_q, cell_err_q;

  logic        hs_fall, vs_fall;
  logic [9:0]  col_d, row_d;
  logic [9:0]  col_wait_cur, col_wait_d, row_wait_d;
  logic [2:0]  col_idx_cur, col_idx_d, row_idx_d;
  logic [6:0]  row_base_d, bit_ptr;
  logic        col_hit, row_hit;
  logic [7:0]  rgb;
  logic [1:0]  code;
  logic        code_bad;
  logic [97:0] shadow_d;
  logic        cell_bad_d, line_err, frame_err, frame_bad_now, frame_bad_d, publish;

  always_comb begin
    hs_fall = hs_d & ~vga.Hsync;
    vs_fall = vs_d & ~vga.Vsync;

    // Position of the pixel presented on this tick.
    col_d = hs_fall ? 10'd0 : ((col_q == 10'h3ff) ? col_q : col_q + 10'd1);
    row_d = row_q;
    if (hs_fall) begin
      row_d = vs_fall ? 10'd0 : ((row_q == 10'h3ff) ? row_q : row_q + 10'd1);
    end

    col_wait_cur = hs_fall ? XStart : col_wait_q;
    col_idx_cur  = hs_fall ? 3'd0 : col_idx_q;
    col_hit      = (col_wait_cur == 10'd0) && (col_idx_cur != IdxDone);
    if (col_hit) begin
      col_wait_d = PitchM1;
      col_idx_d  = col_idx_cur + 3'd1;
    end else begin
      col_wait_d = (col_wait_cur != 10'd0) ? col_wait_cur - 10'd1 : 10'd0;
      col_idx_d  = col_idx_cur;
    end

    // Row tracker advances once per line; index 0 is the selection row, 1..6 the board rows.
    row_wait_d = row_wait_q;
    row_idx_d  = row_idx_q;
    row_base_d = row_base_q;
    if (hs_fall) begin
      if (vs_fall) begin
        row_wait_d = YStart;
        row_idx_d  = 3'd0;
        row_base_d = TopBit;
      end else if ((row_wait_q == 10'd0) && (row_idx_q != IdxDone)) begin
        row_wait_d = (row_idx_q == 3'd0) ? YGapM1 : PitchM1;
        row_idx_d  = row_idx_q + 3'd1;
        row_base_d = row_base_q - 7'd14;
      end else if (row_wait_q != 10'd0) begin
        row_wait_d = row_wait_q - 10'd1;
      end
    end
    row_hit = (row_wait_d == 10'd0) && (row_idx_d != IdxDone);
    bit_ptr = row_base_d - {3'b000, col_idx_cur, 1'b0};

    rgb      = {vga.vgaRed, vga.vgaGreen, vga.vgaBlue};
    code_bad = 1'b0;
    case (rgb)
      8'b000_111_00: code = 2'b01;
      8'b111_000_00: code = 2'b10;
      8'b000_000_00: code = 2'b00;
      default: begin
        code     = 2'b00;
        code_bad = 1'b1;
      end
    endcase

    shadow_d   = shadow_q;
    cell_bad_d = cell_bad_q;
    if (vs_fall) begin
      shadow_d   = '0;
      cell_bad_d = 1'b0;
    end
    if (row_hit && col_hit) begin
      shadow_d[bit_ptr -: 2] = code;
      cell_bad_d             = cell_bad_d | code_bad;
    end

    line_err      = hs_fall && seen_hs_q && (col_q != HLast);
    frame_err     = vs_fall && seen_vs_q && (row_q != VLast);
    frame_bad_now = frame_bad_q | line_err | frame_err;
    // A frame whose start was not seen since reset is never published.
    publish       = vs_fall && seen_vs_q && !frame_bad_now;
    frame_bad_d   = vs_fall ? 1'b0 : frame_bad_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d         <= 1'b1;
      vs_d         <= 1'b1;
      col_q        <= '0;
      row_q        <= '0;
      col_wait_q   <= '0;
      col_idx_q    <= '0;
      row_wait_q   <= '0;
      row_idx_q    <= '0;
      row_base_q   <= TopBit;
      seen_hs_q    <= 1'b0;
      seen_vs_q    <= 1'b0;
      frame_bad_q  <= 1'b0;
      cell_bad_q   <= 1'b0;
      shadow_q     <= '0;
      grid_q       <= '0;
      grid_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      cell_err_q   <= 1'b0;
    end else begin
      grid_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (vga.display_clk) begin
        hs_d        <= vga.Hsync;
        vs_d        <= vga.Vsync;
        col_q       <= col_d;
        row_q       <= row_d;
        col_wait_q  <= col_wait_d;
        col_idx_q   <= col_idx_d;
        row_wait_q  <= row_wait_d;
        row_idx_q   <= row_idx_d;
        row_base_q  <= row_base_d;
        seen_hs_q   <= seen_hs_q | hs_fall;
        seen_vs_q   <= seen_vs_q | vs_fall;
        frame_bad_q <= frame_bad_d;
        cell_bad_q  <= cell_bad_d;
        shadow_q    <= shadow_d;
        sync_err_q  <= line_err | frame_err;
        if (vs_fall) begin
          locked_q <= publish;
          if (publish) begin
            grid_q       <= shadow_q;
            grid_valid_q <= 1'b1;
            cell_err_q   <= cell_bad_q;
          end
        end
      end
    end
  end

  assign vga.grid       = grid_q;
  assign vga.grid_valid = grid_valid_q;
  assign vga.locked     = locked_q;
  assign vga.sync_err   = sync_err_q;
  assign vga.cell_err   = cell_err_q;
endmodule
